// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake over a two-entry skid
// buffer, with a registered in_ready and a control field that is zero on bubbles.
module pipe_skid_reg #(
    parameter int WIDTH      = 16,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy
);

    // State encoding equals the entry count, so occupancy is the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [WIDTH-1:0]      main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [WIDTH-1:0]      skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_n      = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid_in = 1'b1;
                    state_n      = FULL;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_n        = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state       <= EMPTY;
            main_data   <= '0;
            main_ctrl   <= '0;
            skid_data   <= '0;
            skid_ctrl   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            in_ready_q  <= (state_n != FULL);
            out_valid_q <= (state_n != EMPTY);
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    // Side-effecting bits must never leak out on a bubble.
    assign out_ctrl  = out_valid_q ? main_ctrl : '0;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: per-cycle vector table, FIFO-order scoreboard and a
// randomized stream with backpressure and flushes.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_ctrl;
    logic [1:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] exp_q[$];

    pipe_skid_reg #(.WIDTH(16), .CTRL_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inputs and outputs are stable at the falling edge, so the
    // handshakes that will occur at the next rising edge are visible here.
    always @(negedge clk) begin
        logic [19:0] e;
        if (reset !== 1'b1) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_order: got %h/%h with nothing expected", out_data, out_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_ctrl} !== e) begin
                        n_err++;
                        $display("FAIL sb_order: got %h/%h required %h/%h",
                                 out_data, out_ctrl, e[19:4], e[3:0]);
                    end
                end
            end
            if (flush === 1'b1)
                exp_q.delete();
            else if (in_valid === 1'b1 && in_ready === 1'b1)
                exp_q.push_back({in_data, in_ctrl});
        end
    end

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [15:0] id;
        logic [3:0]  ic;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [1:0]  occ;
        logic [3:0]  oc;
        logic        cd;
        logic [15:0] od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [15:0] id, logic [3:0] ic,
                                logic ordy, logic ov, logic ir, logic [1:0] occ, logic [3:0] oc,
                                logic cd, logic [15:0] od);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.occ = occ; v.oc = oc; v.cd = cd; v.od = od;
        return v;
    endfunction

    // Outputs seen one cycle after the vector's inputs were clocked in.
    task automatic check_vec(input int idx, input vec_t v);
        n_vec++;
        if (out_valid !== v.ov || in_ready !== v.ir || occupancy !== v.occ ||
            out_ctrl !== v.oc || (v.cd && out_data !== v.od)) begin
            n_err++;
            $display("FAIL vec%0d: got ov=%b ir=%b occ=%0d ctrl=%h data=%h required ov=%b ir=%b occ=%0d ctrl=%h data=%h%s",
                     idx, out_valid, in_ready, occupancy, out_ctrl, out_data,
                     v.ov, v.ir, v.occ, v.oc, v.od, v.cd ? "" : "(unchecked)");
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;

        // reset held with a pending upstream entry
        vecs.push_back(mk(0,0,1,16'hFFFF,4'hF,0, 0,1,0,4'h0,1,16'h0000));
        vecs.push_back(mk(0,0,1,16'hFFFF,4'hF,0, 0,1,0,4'h0,1,16'h0000));
        // back-to-back streaming
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1,0,1,16'(i),4'(i),1, 1,1,1,4'(i),1,16'(i)));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,1, 0,1,0,4'h0,1,16'h0008));
        // backpressure into the skid slot and release
        vecs.push_back(mk(1,0,1,16'hA000,4'h2,1, 1,1,1,4'h2,1,16'hA000));
        vecs.push_back(mk(1,0,1,16'hA001,4'h3,0, 1,0,2,4'h2,1,16'hA000));
        vecs.push_back(mk(1,0,1,16'hA002,4'h4,0, 1,0,2,4'h2,1,16'hA000));
        vecs.push_back(mk(1,0,1,16'hA002,4'h4,1, 1,1,1,4'h3,1,16'hA001));
        vecs.push_back(mk(1,0,1,16'hA002,4'h4,1, 1,1,1,4'h4,1,16'hA002));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,1, 0,1,0,4'h0,1,16'hA002));
        // flush while full, with an entry offered in the flush cycle
        vecs.push_back(mk(1,0,1,16'hC000,4'hF,0, 1,1,1,4'hF,1,16'hC000));
        vecs.push_back(mk(1,0,1,16'hC001,4'hF,0, 1,0,2,4'hF,1,16'hC000));
        vecs.push_back(mk(1,1,1,16'hBEEF,4'hF,0, 0,1,0,4'h0,0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,0, 0,1,0,4'h0,0,16'h0000));
        // control field only visible while valid
        vecs.push_back(mk(1,0,1,16'h1234,4'hA,0, 1,1,1,4'hA,1,16'h1234));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,0, 1,1,1,4'hA,1,16'h1234));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,1, 0,1,0,4'h0,1,16'h1234));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,1, 0,1,0,4'h0,1,16'h1234));
        // reset while full, then resume
        vecs.push_back(mk(1,0,1,16'hD000,4'h5,0, 1,1,1,4'h5,1,16'hD000));
        vecs.push_back(mk(1,0,1,16'hD001,4'h6,0, 1,0,2,4'h5,1,16'hD000));
        vecs.push_back(mk(0,0,1,16'hD001,4'h6,0, 0,1,0,4'h0,1,16'h0000));
        vecs.push_back(mk(1,0,1,16'h0010,4'h1,1, 1,1,1,4'h1,1,16'h0010));
        vecs.push_back(mk(1,0,0,16'h0,4'h0,1, 0,1,0,4'h0,1,16'h0010));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].id; in_ctrl = vecs[i].ic; out_ready = vecs[i].ordy;
            cycle();
            check_vec(i, vecs[i]);
        end

        // randomized stream: upstream holds its entry until accepted or flushed
        in_valid = 1'b0; flush = 1'b0; reset = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic fire;
            logic fl;
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 16'($urandom);
                in_ctrl  = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            fl        = ($urandom_range(0, 40) == 0);
            flush     = fl;
            @(negedge clk);
            fire = in_valid & in_ready;
            cycle();
            n_vec++;
            if (out_valid == 1'b0 && out_ctrl !== 4'h0) begin
                n_err++;
                $display("FAIL bubble_ctrl: got %h required 0", out_ctrl);
            end
            if (fire || fl) in_valid = 1'b0;
        end

        // drain, bounded
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4 && occupancy != 2'd0; c++) cycle();
        n_vec++;
        if (occupancy !== 2'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got occ=%0d pending=%0d required occ=0 pending=0",
                     occupancy, exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
